// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol modes, standard-order code tables and the
// bit-reverse helper used by both the encoder and the receive-side decoder.
package tmds_pkg;

  typedef enum logic [1:0] {
    TMDS_CTL   = 2'd0,
    TMDS_VID   = 2'd1,
    TMDS_DATA  = 2'd2,
    TMDS_GUARD = 2'd3
  } tmds_mode_e;

  // All tables hold standard q_out order (bit 0 is the first bit on the wire).
  localparam logic [9:0] CTL_CODES [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  localparam logic [9:0] TERC4_CODES [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };

  localparam logic [9:0] GUARD_CODES [3] = '{10'h2CC, 10'h133, 10'h2CC};

  function automatic logic [9:0] bit_rev10(input logic [9:0] w);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[9-i];
    return r;
  endfunction

endpackage

// File: rtl/tmds_qm.sv
// Stage-1 transition minimization: builds the 9-bit q_m word for a pixel and
// the popcount of its low 8 bits, both consumed by the DC-balance stage.
module tmds_qm (
  input  logic [7:0] pix,
  output logic [8:0] qm,
  output logic [3:0] ones
);

  always_comb begin
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 += 4'(pix[i]);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !pix[0]);
    q = '0;
    q[0] = pix[0];
    for (int k = 1; k < 8; k++)
      q[k] = use_xnor ? ~(q[k-1] ^ pix[k]) : (q[k-1] ^ pix[k]);
    q[8] = ~use_xnor;
    ones = '0;
    for (int i = 0; i < 8; i++) ones += 4'(q[i]);
    qm = q;
  end

endmodule

// File: rtl/tmds_encode.sv
// TMDS channel encoder: video / control / TERC4 / guard symbols to 10-bit
// characters, two-cycle latency. TERC4 support is built only with TMDS_TERC4_EN.
module tmds_encode
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_mode,
  input  logic [1:0] i_ctl,
  input  logic [3:0] i_aux,
  input  logic [7:0] i_pix,
  output logic [9:0] o_word
);

  localparam logic [9:0] GUARD = GUARD_CODES[CHANNEL];

  logic [8:0]        qm, qm_r;
  logic [3:0]        ones, ones_r;
  tmds_mode_e        mode_r;
  logic [1:0]        ctl_r;
  logic signed [4:0] cnt;
  logic signed [5:0] cnt_nxt;
  logic [9:0]        q_out;

  tmds_qm u_qm (.pix(i_pix), .qm(qm), .ones(ones));

`ifdef TMDS_TERC4_EN
  logic [3:0] aux_r;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) aux_r <= '0;
    else            aux_r <= i_aux;
`else
  logic unused_aux;
  assign unused_aux = ^i_aux;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      qm_r   <= '0;
      ones_r <= '0;
      mode_r <= TMDS_CTL;
      ctl_r  <= '0;
    end else begin
      qm_r   <= qm;
      ones_r <= ones;
      mode_r <= tmds_mode_e'(i_mode);
      ctl_r  <= i_ctl;
    end
  end

  always_comb begin
    logic signed [5:0] c6, d;
    c6      = {cnt[4], cnt};
    d       = $signed({1'b0, ones_r, 1'b0}) - 6'sd8;  // N1 - N0
    q_out   = CTL_CODES[ctl_r];
    cnt_nxt = '0;  // any non-video symbol restarts the running disparity
    case (mode_r)
      TMDS_VID: begin
        if (cnt == 5'sd0 || ones_r == 4'd4) begin
          q_out   = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
          cnt_nxt = qm_r[8] ? c6 + d : c6 - d;
        end else if ((!cnt[4] && ones_r > 4'd4) || (cnt[4] && ones_r < 4'd4)) begin
          q_out   = {1'b1, qm_r[8], ~qm_r[7:0]};
          cnt_nxt = c6 + (qm_r[8] ? 6'sd2 : 6'sd0) - d;
        end else begin
          q_out   = {1'b0, qm_r[8], qm_r[7:0]};
          cnt_nxt = c6 - (qm_r[8] ? 6'sd0 : 6'sd2) + d;
        end
      end
`ifdef TMDS_TERC4_EN
      TMDS_DATA:  q_out = TERC4_CODES[aux_r];
`endif
      TMDS_GUARD: q_out = GUARD;
      default:    q_out = CTL_CODES[ctl_r];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt    <= '0;
      o_word <= bit_rev10(CTL_CODES[0]);
    end else begin
      cnt    <= cnt_nxt[4:0];
      o_word <= bit_rev10(q_out);
    end
  end

endmodule
